// File: rtl/storage_access_ctrl.sv
// storage_access_ctrl: sequences and polices accesses to the secure storage array.
//   - Round-robin arbiter for two requesters (0 = host, 1 = DMA) onto one storage port.
//   - Each op runs IDLE -> ISSUE -> RESP, so one op takes three cycles and ops never overlap.
//   - Per-region read/write permission table, deny-all after reset, with a sticky lock.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req/req_we/req_addr*/req_wdata* requester side (level req, held until gnt)
//   gnt, done, err, rdata           one-hot grant/completion pulses, violation flag, read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   storage port (1-cycle read latency)
//   cfg_we/cfg_region/cfg_perm/cfg_lock, locked  permission table config and lock status
//   viol_cnt                        saturating count of denied ops
module storage_access_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REGION_BITS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [1:0]             req_we,
    input  logic [ADDR_W-1:0]      req_addr0,
    input  logic [ADDR_W-1:0]      req_addr1,
    input  logic [DATA_W-1:0]      req_wdata0,
    input  logic [DATA_W-1:0]      req_wdata1,
    output logic [1:0]             gnt,
    output logic [1:0]             done,
    output logic                   err,
    output logic [DATA_W-1:0]      rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   cfg_we,
    input  logic [REGION_BITS-1:0] cfg_region,
    input  logic [3:0]             cfg_perm,
    input  logic                   cfg_lock,
    output logic                   locked,
    output logic [7:0]             viol_cnt
);

    localparam int unsigned NUM_REGIONS = 1 << REGION_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched op and arbitration history
    logic              last_q, last_d;       // requester granted most recently
    logic              op_id_q, op_id_d;
    logic              op_allow_q, op_allow_d;
    logic              op_rd_q, op_rd_d;     // op is a read (for rdata qualifier)

    // Next values of registered outputs
    logic [1:0]        gnt_d, done_d;
    logic              err_d, mem_en_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              rd_ok_q, rd_ok_d;     // qualifies mem_rdata onto rdata
    logic [7:0]        viol_d;

    // Permission table: {r1_w, r1_r, r0_w, r0_r} per region
    logic [3:0]        perm_q [NUM_REGIONS];

    // Arbitration inputs for the IDLE decision
    logic                   win_c;
    logic                   we_c;
    logic [ADDR_W-1:0]      addr_c;
    logic [DATA_W-1:0]      wdata_c;
    logic [REGION_BITS-1:0] region_c;
    logic                   allow_c;

    // Winner: sole requester, or the one not granted last when both request
    always_comb begin
        win_c = 1'b0;
        if (req[0] && req[1]) begin
            win_c = ~last_q;
        end else begin
            win_c = req[1];
        end
        we_c     = req_we[win_c];
        addr_c   = win_c ? req_addr1 : req_addr0;
        wdata_c  = win_c ? req_wdata1 : req_wdata0;
        region_c = addr_c[ADDR_W-1 -: REGION_BITS];
        // Table as it stands this cycle; a config write now lands after this decision
        allow_c  = perm_q[region_c][{win_c, we_c}];
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            op_id_q    <= 1'b0;
            op_allow_q <= 1'b0;
            op_rd_q    <= 1'b0;
            gnt        <= 2'b00;
            done       <= 2'b00;
            err        <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd_ok_q    <= 1'b0;
            viol_cnt   <= 8'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            op_id_q    <= op_id_d;
            op_allow_q <= op_allow_d;
            op_rd_q    <= op_rd_d;
            gnt        <= gnt_d;
            done       <= done_d;
            err        <= err_d;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            rd_ok_q    <= rd_ok_d;
            viol_cnt   <= viol_d;
        end
    end

    // Next state and next registered outputs; outputs are set one state early
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_id_d     = op_id_q;
        op_allow_d  = op_allow_q;
        op_rd_d     = op_rd_q;
        gnt_d       = 2'b00;
        done_d      = 2'b00;
        err_d       = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rd_ok_d     = 1'b0;
        viol_d      = viol_cnt;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    last_d      = win_c;
                    op_id_d     = win_c;
                    op_allow_d  = allow_c;
                    op_rd_d     = ~we_c;
                    gnt_d       = win_c ? 2'b10 : 2'b01;
                    // Denied ops never touch storage
                    mem_en_d    = allow_c;
                    mem_we_d    = allow_c & we_c;
                    mem_addr_d  = addr_c;
                    mem_wdata_d = wdata_c;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                done_d  = op_id_q ? 2'b10 : 2'b01;
                err_d   = ~op_allow_q;
                rd_ok_d = op_allow_q & op_rd_q;
                if (!op_allow_q && (viol_cnt != 8'hFF)) begin
                    viol_d = viol_cnt + 8'd1;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Denied reads return zero rather than storage data
    assign rdata = rd_ok_q ? mem_rdata : '0;

    // Permission table and sticky lock; a write alongside the lock pulse still lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGIONS); i++) begin
                perm_q[i] <= 4'b0000;
            end
            locked <= 1'b0;
        end else begin
            if (cfg_we && !locked) begin
                perm_q[cfg_region] <= cfg_perm;
            end
            if (cfg_lock) begin
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: doc/storage_access_ctrl.md
Name: storage_access_ctrl

Overview:
- Sequences and polices all accesses to the 256x32 secure storage array.
- Arbitrates two requesters (0 = host, 1 = DMA) round-robin onto the single storage port.
- Checks each access against a per-region read/write permission table that resets to deny-all.
- The table is written through a config port and can be frozen by a sticky lock until reset.

Parameters:
ADDR_W, 8, storage word address width
DATA_W, 32, storage data width
REGION_BITS, 2, number of address MSBs selecting a permission region (4 regions of 64 words)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  2  per-requester access request, level, held until gnt
req_we  input  2  per-requester write (1) / read (0)
req_addr0  input  ADDR_W  requester 0 address
req_addr1  input  ADDR_W  requester 1 address
req_wdata0  input  DATA_W  requester 0 write data
req_wdata1  input  DATA_W  requester 1 write data
gnt  output  2  one-cycle grant pulse, one-hot
done  output  2  one-cycle completion pulse, one-hot
err  output  1  permission violation; valid with done
rdata  output  DATA_W  read data; valid with done
mem_en  output  1  storage access strobe
mem_we  output  1  storage write enable
mem_addr  output  ADDR_W  storage address
mem_wdata  output  DATA_W  storage write data
mem_rdata  input  DATA_W  storage read data, registered by the storage, 1-cycle latency
cfg_we  input  1  permission table write strobe
cfg_region  input  REGION_BITS  region to write
cfg_perm  input  4  {r1_w, r1_r, r0_w, r0_r}
cfg_lock  input  1  pulse sets sticky lock
locked  output  1  table locked
viol_cnt  output  8  saturating violation count

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - gnt, done, err, mem_en, mem_we = 0; mem_addr, mem_wdata = 0; rdata = 0.
  - All permission entries = 4'b0000 (deny); locked = 0; viol_cnt = 0; RR pointer favours requester 0.
  - An op in flight is dropped with no done.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. One op per 3 cycles; no overlap.
- Cycle T, IDLE with any req bit high:
  - Pick winner W. If only one requester is requesting, it wins. If both request, the one not granted last wins.
  - Latch W, we, addr, wdata.
  - Compute allow from the table as it stands at T: read needs rW_r, write needs rW_w for region addr[7:6].
  - Go to ISSUE.
- T+1 (ISSUE):
  - gnt[W] = 1.
  - mem_en = allow; mem_we = allow & we; mem_addr/mem_wdata = latched values.
  - A denied op issues no storage access (mem_en = 0).
  - Requester may drop req from T+2 onward. Dropping req after T does not cancel the latched op.
- T+2 (RESP):
  - done[W] = 1 and err = ~allow.
  - rdata = mem_rdata when the op is an allowed read; otherwise 0. Denied reads never expose storage data.
  - A denied op increments viol_cnt, saturating at 255.
  - Go to IDLE. A new arbitration can occur at T+3.
- All of gnt, done, err and mem_* are registered. rdata is mem_rdata gated by a registered qualifier.
- Config:
  - cfg_we with locked = 0 writes cfg_perm into entry cfg_region; it takes effect from the next cycle.
  - A config write in the same cycle as an IDLE decision does not affect that decision.
  - cfg_lock = 1 sets locked the next cycle; locked stays set until reset.
  - cfg_we while locked is ignored silently, and viol_cnt is not changed.
  - If cfg_lock and cfg_we are asserted together with locked = 0, the write lands and then the lock sets.
- req ignored outside IDLE. At most one gnt bit and one done bit high in any cycle.

Test Plan:
- Reset, then requester 0 reads addr 0x05 with no config -> gnt[0] at T+1, mem_en = 0, done[0] + err = 1 at T+2, rdata = 0, viol_cnt = 1.
- cfg region 0 perm = 4'b0011, then requester 0 writes 0xDEADBEEF to 0x05 and reads it back -> write: mem_en = mem_we = 1 at T+1, err = 0; read: rdata = 0xDEADBEEF at T+2.
- Both req held continuously, all perms 4'b1111 -> gnt alternates 0,1,0,1 every 3 cycles; never both high.
- Set region 3 perm = 4'b0100, pulse cfg_lock, then write 4'b1111 to region 3 -> locked = 1; requester 1 write to 0xC0 gets err = 1, mem_we = 0; requester 1 read of 0xC0 is allowed.
- Deassert rst_n in the ISSUE cycle of a write -> mem_en drops immediately, no done, table back to deny, locked = 0, viol_cnt = 0.
- 256 denied accesses -> viol_cnt holds at 255.
